// File: rtl/image_window_fetch.sv
// ---------------------------------------------------------------------------
// image_window_fetch
//
// Purpose:
//   Reads the image SRAM and hands KxK windows to the conv engine. After a
//   start pulse it visits every window origin of every channel (stride 1, no
//   padding). The scan order is channel outermost, then row, then column.
//   For each window it issues K*K single-cycle reads in row-major order
//   (ky outer, kx inner). It then presents the assembled window on a
//   valid/ready handshake. This block only ever reads the SRAM.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_start             1-cycle scan request, only honoured while idle
//   o_busy              high from the cycle after start until the done pulse
//   o_done              1-cycle pulse after the final window is accepted
//   o_sram_cs/rd/we     SRAM strobes (we is tied low)
//   o_sram_addr_x/y/c   SRAM pixel column / row / channel
//   i_sram_dout         SRAM read data, valid one cycle after the read cycle
//   o_win_valid         window available
//   i_win_ready         consumer accepts the window when valid && ready
//   o_win_data          byte (ky*K+kx) = pixel(ox+kx, oy+ky, c)
//   o_win_x/y/c         window origin column, row and channel
//   o_win_last          marks the final window of the scan
// ---------------------------------------------------------------------------
module image_window_fetch #(
  parameter int XPIX   = 28,
  parameter int YPIX   = 28,
  parameter int CHANS  = 1,
  parameter int K      = 3,
  parameter int ADDR_W = 5,
  parameter int CH_W   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_sram_cs,
  output logic               o_sram_rd,
  output logic               o_sram_we,
  output logic [ADDR_W-1:0]  o_sram_addr_x,
  output logic [ADDR_W-1:0]  o_sram_addr_y,
  output logic [CH_W-1:0]    o_sram_addr_c,
  input  logic [7:0]         i_sram_dout,
  output logic               o_win_valid,
  input  logic               i_win_ready,
  output logic [8*K*K-1:0]   o_win_data,
  output logic [ADDR_W-1:0]  o_win_x,
  output logic [ADDR_W-1:0]  o_win_y,
  output logic [CH_W-1:0]    o_win_c,
  output logic               o_win_last
);

  localparam int NPIX  = K * K;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [ADDR_W-1:0] OX_MAX  = ADDR_W'(XPIX - K);
  localparam logic [ADDR_W-1:0] OY_MAX  = ADDR_W'(YPIX - K);
  localparam logic [ADDR_W-1:0] KX_MAX  = ADDR_W'(K - 1);
  localparam logic [CH_W-1:0]   C_MAX   = CH_W'(CHANS - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NPIX - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;

  // Window origin and position inside the window
  logic [ADDR_W-1:0]   r_ox;
  logic [ADDR_W-1:0]   r_oy;
  logic [CH_W-1:0]     r_c;
  logic [ADDR_W-1:0]   r_kx;
  logic [IDX_W-1:0]    r_idx;

  // Read-data capture, one cycle behind the read that produced it
  logic                r_cap_en;
  logic [IDX_W-1:0]    r_cap_idx;
  logic [7:0]          r_win [NPIX];

  // Registered outputs
  logic                r_busy;
  logic                r_done;
  logic                r_rd;
  logic [ADDR_W-1:0]   r_addr_x;
  logic [ADDR_W-1:0]   r_addr_y;
  logic [CH_W-1:0]     r_addr_c;
  logic                r_valid;
  logic                r_last;

  // Next window origin
  logic                w_ox_wrap;
  logic                w_oy_wrap;
  logic                w_is_last;
  logic [ADDR_W-1:0]   w_next_ox;
  logic [ADDR_W-1:0]   w_next_oy;
  logic [CH_W-1:0]     w_next_c;

  always_comb begin
    w_ox_wrap = (r_ox == OX_MAX);
    w_oy_wrap = (r_oy == OY_MAX);
    w_is_last = w_ox_wrap && w_oy_wrap && (r_c == C_MAX);

    w_next_ox = w_ox_wrap ? '0 : r_ox + ADDR_W'(1);
    w_next_oy = r_oy;
    w_next_c  = r_c;
    if (w_ox_wrap) begin
      w_next_oy = w_oy_wrap ? '0 : r_oy + ADDR_W'(1);
      if (w_oy_wrap) begin
        // The channel index also wraps after the final window. The origin
        // is then back at 0 for the next scan without extra logic.
        w_next_c = (r_c == C_MAX) ? '0 : r_c + CH_W'(1);
      end
    end
  end

  // Control FSM. Every output is registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_ox      <= '0;
      r_oy      <= '0;
      r_c       <= '0;
      r_kx      <= '0;
      r_idx     <= '0;
      r_cap_en  <= 1'b0;
      r_cap_idx <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd      <= 1'b0;
      r_addr_x  <= '0;
      r_addr_y  <= '0;
      r_addr_c  <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_cap_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_FETCH;
            r_busy   <= 1'b1;
            r_rd     <= 1'b1;
            r_ox     <= '0;
            r_oy     <= '0;
            r_c      <= '0;
            r_kx     <= '0;
            r_idx    <= '0;
            r_addr_x <= '0;
            r_addr_y <= '0;
            r_addr_c <= '0;
          end
        end

        S_FETCH: begin
          // The read issued this cycle returns data next cycle. Remember
          // which window byte it belongs to.
          r_cap_en  <= 1'b1;
          r_cap_idx <= r_idx;
          if (r_idx == IDX_MAX) begin
            r_rd    <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_kx == KX_MAX) begin
              r_kx     <= '0;
              r_addr_x <= r_ox;
              r_addr_y <= r_addr_y + ADDR_W'(1);
            end else begin
              r_kx     <= r_kx + ADDR_W'(1);
              r_addr_x <= r_addr_x + ADDR_W'(1);
            end
          end
        end

        S_DRAIN: begin
          r_valid <= 1'b1;
          r_last  <= w_is_last;
          r_state <= S_OUT;
        end

        S_OUT: begin
          if (i_win_ready) begin
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_ox     <= w_next_ox;
            r_oy     <= w_next_oy;
            r_c      <= w_next_c;
            r_kx     <= '0;
            r_idx    <= '0;
            if (w_is_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state  <= S_FETCH;
              r_rd     <= 1'b1;
              r_addr_x <= w_next_ox;
              r_addr_y <= w_next_oy;
              r_addr_c <= w_next_c;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Window byte capture. This covers FETCH cycles 1..K*K-1 and the DRAIN
  // cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NPIX; i++) begin
        r_win[i] <= '0;
      end
    end else if (r_cap_en) begin
      r_win[r_cap_idx] <= i_sram_dout;
    end
  end

  for (genvar gi = 0; gi < NPIX; gi++) begin : g_pack
    assign o_win_data[gi*8 +: 8] = r_win[gi];
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_sram_cs     = r_rd;
  assign o_sram_rd     = r_rd;
  assign o_sram_we     = 1'b0;
  assign o_sram_addr_x = r_addr_x;
  assign o_sram_addr_y = r_addr_y;
  assign o_sram_addr_c = r_addr_c;
  assign o_win_valid   = r_valid;
  assign o_win_x       = r_ox;
  assign o_win_y       = r_oy;
  assign o_win_c       = r_c;
  assign o_win_last    = r_last;

endmodule
